// File: rtl/regfile_pkg.sv
`default_nettype none
// =============================================================================
// Module      : regfile_pkg
// Description : Default sizes and shared typedefs for the register file slice.
// Revision    : 1.0 - initial release
// =============================================================================
package regfile_pkg;
    localparam int c_XLEN_DEFAULT  = 32;
    localparam int c_NREGS_DEFAULT = 32;
    localparam int c_NRP_DEFAULT   = 2;
    localparam int c_AW_DEFAULT    = $clog2(c_NREGS_DEFAULT);

    typedef logic [c_XLEN_DEFAULT-1:0] word_t;
    typedef logic [c_AW_DEFAULT-1:0]   reg_addr_t;
endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// =============================================================================
// Module      : regfile_scoreboard_if
// Description : Read, writeback, issue and status signals of the register file.
// Revision    : 1.0 - initial release
// =============================================================================
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = c_XLEN_DEFAULT,
    parameter int NREGS = c_NREGS_DEFAULT,
    parameter int NRP   = c_NRP_DEFAULT
);
    localparam int AW = $clog2(NREGS);

    logic [NRP-1:0][AW-1:0]   ra;
    logic [NRP-1:0][XLEN-1:0] rd;
    logic [NRP-1:0]           rbusy;
    logic                     we;
    logic [AW-1:0]            wa;
    logic [XLEN-1:0]          wd;
    logic                     iss_valid;
    logic [AW-1:0]            iss_rd;
    logic [AW:0]              busy_cnt;
    logic                     wb_spurious;

    modport master (
        output ra, we, wa, wd, iss_valid, iss_rd,
        input  rd, rbusy, busy_cnt, wb_spurious
    );

    modport slave (
        input  ra, we, wa, wd, iss_valid, iss_rd,
        output rd, rbusy, busy_cnt, wb_spurious
    );
endinterface
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// =============================================================================
// Module      : rf_scoreboard
// Description : Per-register busy tracking, busy count and spurious-writeback flag.
// Revision    : 1.0 - initial release
// =============================================================================
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NREGS = c_NREGS_DEFAULT,
    localparam int AW    = $clog2(NREGS)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_iss_valid,
    input  wire logic [AW-1:0]    i_iss_rd,
    input  wire logic             i_we,
    input  wire logic [AW-1:0]    i_wa,
    output logic      [NREGS-1:0] o_busy,
    output logic      [AW:0]      o_busy_cnt,
    output logic                  o_wb_spurious
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      r_cnt;
    logic [AW:0]      w_cnt_nxt;
    logic             r_spur;
    logic             w_spur_nxt;

    // Issue is applied after writeback so a new producer keeps ownership.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_we && (i_wa != '0)) begin
            w_busy_nxt[i_wa] = 1'b0;
        end
        if (i_iss_valid && (i_iss_rd != '0)) begin
            w_busy_nxt[i_iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
        w_cnt_nxt = '0;
        for (int k = 0; k < NREGS; k++) begin
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[k]};
        end
        w_spur_nxt = i_we && (i_wa != '0) && !r_busy[i_wa];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
            r_spur <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
            r_spur <= w_spur_nxt;
        end
    end

    assign o_busy        = r_busy;
    assign o_busy_cnt    = r_cnt;
    assign o_wb_spurious = r_spur;
endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// =============================================================================
// Module      : regfile_scoreboard
// Description : Multi-port register file with write bypass and producer scoreboard.
// Revision    : 1.0 - initial release
// =============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  XLEN  = c_XLEN_DEFAULT,
    parameter int  NREGS = c_NREGS_DEFAULT,
    parameter int  NRP   = c_NRP_DEFAULT,
    localparam int AW    = $clog2(NREGS)
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    regfile_scoreboard_if.slave bus
);
    logic [XLEN-1:0]          r_regs [NREGS];
    logic [NREGS-1:0]         w_busy;
    logic                     w_wr_en;
    logic [NRP-1:0]           w_hit;
    logic [NRP-1:0][XLEN-1:0] w_rd;
    logic [NRP-1:0]           w_rbusy;

    assign w_wr_en = bus.we && (bus.wa != '0);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[bus.wa] <= bus.wd;
        end
    end

    always_comb begin
        w_hit   = '0;
        w_rd    = '0;
        w_rbusy = '0;
        for (int i = 0; i < NRP; i++) begin
            w_hit[i] = w_wr_en && (bus.wa == bus.ra[i]);
            if (w_hit[i]) begin
                w_rd[i] = bus.wd;
            end else if (bus.ra[i] != '0) begin
                w_rd[i] = r_regs[bus.ra[i]];
            end
            w_rbusy[i] = w_busy[bus.ra[i]] && !w_hit[i];
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_iss_valid   (bus.iss_valid),
        .i_iss_rd      (bus.iss_rd),
        .i_we          (bus.we),
        .i_wa          (bus.wa),
        .o_busy        (w_busy),
        .o_busy_cnt    (bus.busy_cnt),
        .o_wb_spurious (bus.wb_spurious)
    );

    assign bus.rd    = w_rd;
    assign bus.rbusy = w_rbusy;
endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// =============================================================================
// Module      : tb_regfile_scoreboard
// Description : Directed and random checks of regfile_scoreboard against an array model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int c_XL = 32;
    localparam int c_NR = 32;
    localparam int c_NP = 2;
    localparam int c_AW = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [c_XL-1:0] m_reg  [c_NR];
    bit              m_busy [c_NR];
    bit              m_spur;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(c_XL), .NREGS(c_NR), .NRP(c_NP)) bus ();

    regfile_scoreboard #(.XLEN(c_XL), .NREGS(c_NR), .NRP(c_NP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < c_NR; k++) c += int'(m_busy[k]);
        return c;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < c_NR; k++) begin
            m_reg[k]  = '0;
            m_busy[k] = 1'b0;
        end
        m_spur = 1'b0;
    endtask

    task automatic drive(input logic we, input int wa, input logic [31:0] wd,
                         input logic iv, input int ird, input int ra0, input int ra1);
        bus.we        = we;
        bus.wa        = c_AW'(wa);
        bus.wd        = wd;
        bus.iss_valid = iv;
        bus.iss_rd    = c_AW'(ird);
        bus.ra[0]     = c_AW'(ra0);
        bus.ra[1]     = c_AW'(ra1);
    endtask

    task automatic check_comb(input string tag);
        logic [c_AW-1:0] a;
        logic [c_XL-1:0] e;
        bit              hit;
        bit              eb;
        for (int i = 0; i < c_NP; i++) begin
            a   = bus.ra[i];
            hit = bus.we && (bus.wa != 0) && (bus.wa == a);
            if (a == 0)   e = '0;
            else if (hit) e = bus.wd;
            else          e = m_reg[a];
            eb = (a != 0) && m_busy[a] && !hit;
            chk($sformatf("%s_rd%0d", tag, i), 64'(bus.rd[i]), 64'(e));
            chk($sformatf("%s_rbusy%0d", tag, i), 64'(bus.rbusy[i]), 64'(eb));
        end
    endtask

    task automatic tick(input string tag);
        bit spur;
        spur = bus.we && (bus.wa != 0) && !m_busy[bus.wa];
        @(posedge clk);
        if (bus.we && bus.wa != 0) begin
            m_reg[bus.wa]  = bus.wd;
            m_busy[bus.wa] = 1'b0;
        end
        if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
        m_spur = spur;
        #1;
        chk({tag, "_cnt"}, 64'(bus.busy_cnt), 64'(m_count()));
        chk({tag, "_spur"}, 64'(bus.wb_spurious), 64'(m_spur));
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        #1;
        check_comb(tag);
        tick(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int wa;
        int ra0;
        int ra1;
        rst_n = 1'b0;
        m_clear();
        drive(0, 0, 0, 0, 0, 1, 2);
        #1;
        check_comb("in_reset");
        chk("in_reset_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("in_reset_spur", 64'(bus.wb_spurious), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_rd0", 64'(bus.rd[0]), 64'd0);
        chk("post_reset_rd1", 64'(bus.rd[1]), 64'd0);
        chk("post_reset_rbusy", 64'(bus.rbusy), 64'd0);
        chk("post_reset_cnt", 64'(bus.busy_cnt), 64'd0);
        @(negedge clk);

        // Bypass, then the stored value on the following cycle.
        drive(1, 3, 32'h0000_000F, 0, 0, 3, 0);
        #1;
        chk("bypass_rd0", 64'(bus.rd[0]), 64'h0F);
        step("bypass");
        drive(0, 0, 0, 0, 0, 3, 0);
        #1;
        chk("stored_rd0", 64'(bus.rd[0]), 64'h0F);
        step("stored");

        // Register 0 ignores writes and issues.
        drive(1, 0, 32'hDEAD_BEEF, 1, 0, 0, 0);
        step("r0_write");
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("r0_rd0", 64'(bus.rd[0]), 64'd0);
        chk("r0_cnt", 64'(bus.busy_cnt), 64'd0);
        step("r0_idle");

        // Issue then writeback of register 5.
        drive(0, 0, 0, 1, 5, 0, 0);
        step("iss5");
        drive(0, 0, 0, 0, 0, 0, 5);
        #1;
        chk("iss5_rbusy1", 64'(bus.rbusy[1]), 64'd1);
        chk("iss5_cnt", 64'(bus.busy_cnt), 64'd1);
        step("iss5_read");
        drive(1, 5, 32'h0000_00AA, 0, 0, 0, 5);
        #1;
        chk("wb5_rbusy1", 64'(bus.rbusy[1]), 64'd0);
        step("wb5");
        chk("wb5_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("wb5_spur", 64'(bus.wb_spurious), 64'd0);

        // Same-edge issue and writeback: the new producer wins.
        drive(0, 0, 0, 1, 7, 0, 0);
        step("iss7");
        drive(1, 7, 32'h0000_0077, 1, 7, 7, 0);
        step("iss_wb7");
        chk("iss_wb7_cnt", 64'(bus.busy_cnt), 64'd1);
        chk("iss_wb7_spur", 64'(bus.wb_spurious), 64'd0);
        drive(0, 0, 0, 0, 0, 7, 0);
        #1;
        chk("iss_wb7_rbusy0", 64'(bus.rbusy[0]), 64'd1);
        chk("iss_wb7_rd0", 64'(bus.rd[0]), 64'h77);
        step("iss_wb7_read");

        // Writeback to a register that was never issued.
        drive(1, 9, 32'h0000_0099, 0, 0, 9, 9);
        step("spur9");
        chk("spur9_pulse", 64'(bus.wb_spurious), 64'd1);
        drive(0, 0, 0, 0, 0, 9, 9);
        step("spur9_after");
        chk("spur9_clear", 64'(bus.wb_spurious), 64'd0);

        for (int n = 0; n < 300; n++) begin
            wa  = int'($urandom_range(0, c_NR - 1));
            ra0 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, c_NR - 1));
            ra1 = ($urandom_range(0, 3) == 0) ? ra0 : int'($urandom_range(0, c_NR - 1));
            drive(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, c_NR - 1)), ra0, ra1);
            step("rand");
        end

        // Asynchronous reset in mid-cycle with three producers outstanding.
        rst_n = 1'b0;
        #1;
        m_clear();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 10, 32'h0000_1234, 1, 11, 0, 0);
        step("pre_a");
        drive(0, 0, 0, 1, 12, 0, 0);
        step("pre_b");
        drive(0, 0, 0, 1, 13, 0, 0);
        step("pre_c");
        chk("pre_cnt3", 64'(bus.busy_cnt), 64'd3);
        drive(0, 0, 0, 0, 0, 10, 11);
        #1;
        chk("pre_rd0", 64'(bus.rd[0]), 64'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        m_clear();
        chk("arst_rd0", 64'(bus.rd[0]), 64'd0);
        chk("arst_rbusy1", 64'(bus.rbusy[1]), 64'd0);
        chk("arst_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("arst_spur", 64'(bus.wb_spurious), 64'd0);
        drive(1, 20, 32'h0000_0055, 1, 21, 20, 21);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 20, 21);
        #1;
        chk("lost_rd0", 64'(bus.rd[0]), 64'd0);
        chk("lost_rbusy1", 64'(bus.rbusy[1]), 64'd0);
        check_comb("lost");
        @(negedge clk);
        drive(0, 0, 0, 1, 22, 0, 22);
        step("first_edge");
        chk("first_edge_cnt", 64'(bus.busy_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
